dtw_result_filter: RTL and testbench
====================================

DTW_RESULT_FILTER -- requirements
Module: dtw_result_filter

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 32, width of input/output stream data (fixed 32 in this revision).
REQ-002 SHALL have parameter COST_WIDTH, default 16, width of the DTW cost field.
REQ-003 SHALL have parameter POS_WIDTH, default 15, width of the reference-position field.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_axis_tvalid  input  1  upstream beat valid (fed from the DTW accelerator sink stream).
REQ-007 SHALL have port o_axis_tready  output  1  beat accepted when tvalid && tready.
REQ-008 SHALL have port i_axis_tdata  input  32  [15:0] cost, [30:16] ref position, [31] ignored.
REQ-009 SHALL have port i_axis_tlast  input  1  final beat of one read.
REQ-010 SHALL have port i_axis_tuser  input  1  ignored.
REQ-011 SHALL have port o_res_tvalid  output  1  result word valid.
REQ-012 SHALL have port i_res_tready  input  1  downstream ready.
REQ-013 SHALL have port o_res_tdata  output  32  [15:0] min cost, [30:16] position of min, [31] match.
REQ-014 SHALL have port o_res_tlast  output  1  constant 1 (single-beat result packet).
REQ-015 SHALL have port i_threshold  input  16  match threshold on cost.
REQ-016 SHALL have port i_stat_clear  input  1  one-cycle strobe clearing statistics counters.
REQ-017 SHALL have port o_reads_total  output  32  count of results emitted.
REQ-018 SHALL have port o_reads_matched  output  32  count of emitted results with match=1.
REQ-019 SHALL have port o_busy  output  1  high when state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ACCUM, EMIT.
REQ-021 IDLE/ACCUM: o_axis_tready=1; EMIT: o_axis_tready=0 (backpressure upstream).
REQ-022 First accepted beat in IDLE SHALL load min_cost/min_pos unconditionally from the beat, then go to ACCUM (or EMIT if tlast).
REQ-023 Accepted beat in ACCUM SHALL replace min only if cost < min_cost (strictly less, unsigned); ties keep earliest beat.
REQ-024 Accepted beat with tlast SHALL include that beat in the min, latch the result, and enter EMIT the next cycle.
REQ-025 match SHALL be (final min_cost < i_threshold), evaluated with i_threshold sampled in the tlast acceptance cycle; threshold 0 never matches.
REQ-026 o_res_tvalid SHALL assert the cycle after the tlast beat is accepted (1-cycle latency) and hold with stable o_res_tdata until i_res_tready.
REQ-027 On the o_res handshake, SHALL return to IDLE next cycle; o_axis_tready rises the same cycle as the state change.
REQ-028 A single-beat read (tlast on first beat) SHALL yield that beat's cost/position.
REQ-029 On each o_res handshake, o_reads_total SHALL increment by 1, o_reads_matched by match; both wrap modulo 2^32.
REQ-030 i_stat_clear SHALL zero both counters next cycle; if coincident with a handshake, clear wins (increment dropped).
REQ-031 Beats with tvalid low SHALL not alter state or min registers; tdata bit 31 and tuser SHALL not affect results.

Reset
REQ-032 On rst high at a clock edge: state=IDLE, o_res_tvalid=0, o_res_tdata=0, o_busy=0, counters=0, min registers=0; o_axis_tready=1 the cycle after rst deasserts.
REQ-033 rst mid-read or mid-EMIT SHALL discard the partial/pending result with no counter update.

Verification
REQ-034 Read of costs 500,120,300(tlast) at pos 0,1,2, threshold 200 -> one result: cost 120, pos 1, match 1; total=1, matched=1.
REQ-035 Costs 80,80(tlast) at pos 5,9, threshold 80 -> cost 80, pos 5, match 0 (strict compare, earliest tie).
REQ-036 Hold i_res_tready=0 for 10 cycles after tlast -> o_res_tvalid/tdata stable, o_axis_tready=0 throughout, no lost upstream beats.
REQ-037 Back-to-back single-beat reads with i_res_tready=1 -> one result per read, each 1 cycle after its beat, counters track exactly.
REQ-038 Assert rst during ACCUM after 3 beats, then send read 40(tlast) -> result cost 40, total=1.
REQ-039 i_stat_clear in same cycle as result handshake -> counters read 0 next cycle.

Source files
------------

// File: rtl/dtw_result_filter.sv
// dtw_result_filter: reduces one DTW read (a stream of cost/position beats)
// to a single result word holding the minimum cost, the position where it
// first occurred and a threshold match flag. It also keeps running counts
// of emitted and matched results.
module dtw_result_filter #(
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int COST_WIDTH      = 16,
   parameter int POS_WIDTH       = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_axis_tvalid,
   output logic                       o_axis_tready,
   input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
   input  logic                       i_axis_tlast,
   input  logic                       i_axis_tuser,
   output logic                       o_res_tvalid,
   input  logic                       i_res_tready,
   output logic [AXIS_DATA_WIDTH-1:0] o_res_tdata,
   output logic                       o_res_tlast,
   input  logic [COST_WIDTH-1:0]      i_threshold,
   input  logic                       i_stat_clear,
   output logic [31:0]                o_reads_total,
   output logic [31:0]                o_reads_matched,
   output logic                       o_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } state_t;

   state_t                       state_r, state_next_s;
   logic [COST_WIDTH-1:0]        min_cost_r, min_cost_next_s;
   logic [POS_WIDTH-1:0]         min_pos_r, min_pos_next_s;
   logic                         res_valid_r, res_valid_next_s;
   logic [AXIS_DATA_WIDTH-1:0]   res_data_r, res_data_next_s;
   logic                         tready_r;
   logic                         busy_r;
   logic [31:0]                  total_r, total_next_s;
   logic [31:0]                  matched_r, matched_next_s;

   logic [COST_WIDTH-1:0]        beat_cost_s;
   logic [POS_WIDTH-1:0]         beat_pos_s;
   logic                         accept_s;
   logic                         handshake_s;
   logic                         take_beat_s;
   logic [COST_WIDTH-1:0]        sel_cost_s;
   logic [POS_WIDTH-1:0]         sel_pos_s;
   logic                         match_s;
   logic [AXIS_DATA_WIDTH-1:0]   res_word_s;
   logic                         unused_s;

   // Bit 31 of the beat and tuser carry no meaning for the result.
   assign unused_s = &{1'b0, i_axis_tdata[AXIS_DATA_WIDTH-1], i_axis_tuser};

   assign beat_cost_s  = i_axis_tdata[COST_WIDTH-1:0];
   assign beat_pos_s   = i_axis_tdata[COST_WIDTH +: POS_WIDTH];
   assign accept_s     = i_axis_tvalid & tready_r;
   assign handshake_s  = res_valid_r & i_res_tready;

   // First beat of a read always loads; later beats win only on a strictly
   // lower cost so ties keep the earliest position.
   assign take_beat_s  = (state_r == IDLE) || (beat_cost_s < min_cost_r);
   assign sel_cost_s   = take_beat_s ? beat_cost_s : min_cost_r;
   assign sel_pos_s    = take_beat_s ? beat_pos_s  : min_pos_r;
   assign match_s      = (sel_cost_s < i_threshold);

   // Assemble the result word from the minimum that includes the current beat.
   always_comb begin
      res_word_s                              = {AXIS_DATA_WIDTH{1'b0}};
      res_word_s[COST_WIDTH-1:0]              = sel_cost_s;
      res_word_s[COST_WIDTH +: POS_WIDTH]     = sel_pos_s;
      res_word_s[AXIS_DATA_WIDTH-1]           = match_s;
   end

   // Next-state logic: accumulate the minimum, latch the result on tlast,
   // hold it in EMIT until the downstream handshake.
   always_comb begin
      state_next_s     = state_r;
      min_cost_next_s  = min_cost_r;
      min_pos_next_s   = min_pos_r;
      res_valid_next_s = res_valid_r;
      res_data_next_s  = res_data_r;
      case (state_r)
         IDLE, ACCUM: begin
            if (accept_s) begin
               min_cost_next_s = sel_cost_s;
               min_pos_next_s  = sel_pos_s;
               if (i_axis_tlast) begin
                  state_next_s     = EMIT;
                  res_valid_next_s = 1'b1;
                  res_data_next_s  = res_word_s;
               end else begin
                  state_next_s     = ACCUM;
               end
            end else begin
               state_next_s = state_r;
            end
         end
         EMIT: begin
            if (handshake_s) begin
               state_next_s     = IDLE;
               res_valid_next_s = 1'b0;
            end else begin
               state_next_s     = EMIT;
            end
         end
         default: begin
            state_next_s     = IDLE;
            res_valid_next_s = 1'b0;
         end
      endcase
   end

   // Statistics counters; a clear strobe overrides a coincident handshake.
   always_comb begin
      total_next_s   = total_r;
      matched_next_s = matched_r;
      if (i_stat_clear) begin
         total_next_s   = 32'd0;
         matched_next_s = 32'd0;
      end else if (handshake_s) begin
         total_next_s   = total_r + 32'd1;
         matched_next_s = matched_r + {31'd0, res_data_r[AXIS_DATA_WIDTH-1]};
      end else begin
         total_next_s   = total_r;
         matched_next_s = matched_r;
      end
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         min_cost_r  <= {COST_WIDTH{1'b0}};
         min_pos_r   <= {POS_WIDTH{1'b0}};
         res_valid_r <= 1'b0;
         res_data_r  <= {AXIS_DATA_WIDTH{1'b0}};
         tready_r    <= 1'b1;
         busy_r      <= 1'b0;
         total_r     <= 32'd0;
         matched_r   <= 32'd0;
      end else begin
         state_r     <= state_next_s;
         min_cost_r  <= min_cost_next_s;
         min_pos_r   <= min_pos_next_s;
         res_valid_r <= res_valid_next_s;
         res_data_r  <= res_data_next_s;
         tready_r    <= (state_next_s != EMIT);
         busy_r      <= (state_next_s != IDLE);
         total_r     <= total_next_s;
         matched_r   <= matched_next_s;
      end
   end

   assign o_axis_tready   = tready_r;
   assign o_res_tvalid    = res_valid_r;
   assign o_res_tdata     = res_data_r;
   assign o_res_tlast     = 1'b1;
   assign o_reads_total   = total_r;
   assign o_reads_matched = matched_r;
   assign o_busy          = busy_r;

endmodule

// File: tb/tb_dtw_result_filter.sv
// Bench for dtw_result_filter: a read-level reference model (queue of beats,
// minimum picked when tlast is taken) checked against the DUT every cycle,
// plus directed reads with literal expected result words and counter values.
module tb_dtw_result_filter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_axis_tvalid;
   logic        o_axis_tready;
   logic [31:0] i_axis_tdata;
   logic        i_axis_tlast;
   logic        i_axis_tuser;
   logic        o_res_tvalid;
   logic        i_res_tready;
   logic [31:0] o_res_tdata;
   logic        o_res_tlast;
   logic [15:0] i_threshold;
   logic        i_stat_clear;
   logic [31:0] o_reads_total;
   logic [31:0] o_reads_matched;
   logic        o_busy;

   int vec_cnt = 0;
   int err_cnt = 0;

   // reference model state
   logic [31:0] beats_q[$];
   bit          m_live = 1'b0;
   bit          m_pending;
   bit          m_hs;
   logic [31:0] m_result;
   logic [31:0] m_total;
   logic [31:0] m_matched;

   always #5 clk = ~clk;

   dtw_result_filter dut (
      .clk             (clk),
      .rst             (rst),
      .i_axis_tvalid   (i_axis_tvalid),
      .o_axis_tready   (o_axis_tready),
      .i_axis_tdata    (i_axis_tdata),
      .i_axis_tlast    (i_axis_tlast),
      .i_axis_tuser    (i_axis_tuser),
      .o_res_tvalid    (o_res_tvalid),
      .i_res_tready    (i_res_tready),
      .o_res_tdata     (o_res_tdata),
      .o_res_tlast     (o_res_tlast),
      .i_threshold     (i_threshold),
      .i_stat_clear    (i_stat_clear),
      .o_reads_total   (o_reads_total),
      .o_reads_matched (o_reads_matched),
      .o_busy          (o_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // minimum over the collected read: earliest of the strictly-lowest costs
   function automatic logic [31:0] best_of_read(input logic [15:0] thr);
      logic [15:0] cost;
      logic [14:0] pos;
      cost = beats_q[0][15:0];
      pos  = beats_q[0][30:16];
      for (int i = 1; i < beats_q.size(); i++) begin
         if (beats_q[i][15:0] < cost) begin
            cost = beats_q[i][15:0];
            pos  = beats_q[i][30:16];
         end
      end
      return {(cost < thr), pos, cost};
   endfunction

   // reference model, advanced once per rising edge
   initial forever begin
      @(posedge clk);
      if (rst) begin
         beats_q.delete();
         m_pending = 1'b0;
         m_result  = 32'd0;
         m_total   = 32'd0;
         m_matched = 32'd0;
         m_live    = 1'b1;
      end else if (m_live) begin
         m_hs = m_pending && i_res_tready;
         if (i_stat_clear) begin
            m_total   = 32'd0;
            m_matched = 32'd0;
         end else if (m_hs) begin
            m_total   = m_total + 32'd1;
            m_matched = m_matched + {31'd0, m_result[31]};
         end
         if (m_hs) begin
            m_pending = 1'b0;
         end else if (!m_pending && i_axis_tvalid) begin
            beats_q.push_back(i_axis_tdata);
            if (i_axis_tlast) begin
               m_result  = best_of_read(i_threshold);
               m_pending = 1'b1;
               beats_q.delete();
            end
         end
      end
   end

   // per-cycle comparison against the model, away from the active edge
   initial forever begin
      @(negedge clk);
      if (m_live) begin
         check("tready",  {31'd0, o_axis_tready},   {31'd0, !m_pending});
         check("tvalid",  {31'd0, o_res_tvalid},    {31'd0, m_pending});
         if (m_pending) check("tdata", o_res_tdata, m_result);
         check("tlast",   {31'd0, o_res_tlast},     32'd1);
         check("total",   o_reads_total,            m_total);
         check("matched", o_reads_matched,          m_matched);
         check("busy",    {31'd0, o_busy},          {31'd0, (m_pending || beats_q.size() != 0)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // offer one beat and hold it until the DUT takes it (bounded)
   task automatic send(input logic [15:0] cost, input logic [14:0] pos,
                       input logic last, input logic junk);
      bit done;
      done          = 1'b0;
      i_axis_tvalid = 1'b1;
      i_axis_tdata  = {junk, pos, cost};
      i_axis_tlast  = last;
      i_axis_tuser  = junk;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         done = o_axis_tready;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL accept_timeout: beat cost %0d never accepted", cost);
      end
      i_axis_tvalid = 1'b0;
      i_axis_tlast  = 1'b0;
      i_axis_tdata  = 32'd0;
      i_axis_tuser  = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; i_axis_tvalid = 1'b0; i_axis_tdata = 32'd0; i_axis_tlast = 1'b0;
      i_axis_tuser = 1'b0; i_res_tready = 1'b0; i_threshold = 16'd200; i_stat_clear = 1'b0;
      tick(); tick();
      check("rst_tdata",  o_res_tdata, 32'd0);
      check("rst_total",  o_reads_total, 32'd0);
      check("rst_busy",   {31'd0, o_busy}, 32'd0);
      rst = 1'b0;
      tick();
      check("rst_tready", {31'd0, o_axis_tready}, 32'd1);

      // 500,120,300 at pos 0,1,2, threshold 200
      send(16'd500, 15'd0, 1'b0, 1'b1);
      send(16'd120, 15'd1, 1'b0, 1'b0);
      send(16'd300, 15'd2, 1'b1, 1'b1);
      check("r1_word", o_res_tdata, 32'h8001_0078);
      i_res_tready = 1'b1;
      tick();
      check("r1_total",   o_reads_total,   32'd1);
      check("r1_matched", o_reads_matched, 32'd1);
      i_res_tready = 1'b0;

      // equal costs at pos 5,9 with threshold 80: earliest tie, no match
      i_threshold = 16'd80;
      send(16'd80, 15'd5, 1'b0, 1'b0);
      send(16'd80, 15'd9, 1'b1, 1'b0);
      check("tie_word", o_res_tdata, 32'h0005_0050);
      i_res_tready = 1'b1;
      tick();
      i_res_tready = 1'b0;

      // threshold 0 never matches, even for cost 0; junk bits set
      i_threshold = 16'd0;
      send(16'd0, 15'd3, 1'b1, 1'b1);
      check("thr0_word", o_res_tdata, 32'h0003_0000);
      i_res_tready = 1'b1;
      tick();
      i_res_tready = 1'b0;

      // hold downstream ready low for 10 cycles while the next read waits
      i_threshold = 16'd200;
      send(16'd300, 15'd4, 1'b0, 1'b0);
      send(16'd250, 15'd6, 1'b0, 1'b0);
      send(16'd260, 15'd7, 1'b1, 1'b0);
      fork
         send(16'd777, 15'd8, 1'b1, 1'b0);
         begin
            repeat (10) begin
               check("hold_tready", {31'd0, o_axis_tready}, 32'd0);
               check("hold_word",   o_res_tdata, 32'h0006_00FA);
               tick();
            end
            i_res_tready = 1'b1;
         end
      join
      tick();
      check("hold_total", o_reads_total, 32'd5);

      // back-to-back single-beat reads, threshold 100
      i_threshold = 16'd100;
      send(16'd10,  15'd1, 1'b1, 1'b0);
      send(16'd20,  15'd2, 1'b1, 1'b1);
      send(16'd300, 15'd3, 1'b1, 1'b0);
      send(16'd5,   15'd4, 1'b1, 1'b0);
      tick();
      check("b2b_total",   o_reads_total,   32'd9);
      check("b2b_matched", o_reads_matched, 32'd4);

      // clear coincident with handshake: clear wins
      i_res_tready = 1'b0;
      send(16'd1, 15'd2, 1'b1, 1'b0);
      i_res_tready = 1'b1;
      i_stat_clear = 1'b1;
      tick();
      i_stat_clear = 1'b0;
      check("clr_total",   o_reads_total,   32'd0);
      check("clr_matched", o_reads_matched, 32'd0);

      // reset during ACCUM after three beats, then a fresh single-beat read
      i_threshold = 16'd200;
      send(16'd900, 15'd1, 1'b0, 1'b0);
      send(16'd901, 15'd2, 1'b0, 1'b0);
      send(16'd3,   15'd3, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send(16'd40, 15'd11, 1'b1, 1'b0);
      tick();
      check("rstacc_total",   o_reads_total,   32'd1);
      check("rstacc_matched", o_reads_matched, 32'd1);

      // reset while a result is pending downstream
      i_res_tready = 1'b0;
      send(16'd55, 15'd12, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      i_res_tready = 1'b1;
      tick();
      check("rstemit_valid", {31'd0, o_res_tvalid}, 32'd0);
      check("rstemit_total", o_reads_total, 32'd0);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
